respondedor_memoria: RTL and testbench
======================================

RESPONDEDOR_MEMORIA -- requirements
Module: respondedor_memoria

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving the clock edges from request capture to ack (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit words stored.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req, input, 1 bit: initiator request, held high until ack.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address.
REQ-008 The block SHALL have port dtype, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 The block SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port rdata, output, 32 bits: load result, valid while ack=1.
REQ-012 The block SHALL have port err, output, 1 bit: request rejected, valid while ack=1.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-015 IDLE with req=1 SHALL capture we, addr, dtype and wdata, load the counter with LATENCY-1, and go to WAIT; inputs SHALL be ignored after capture.
REQ-016 WAIT SHALL decrement the counter each edge; at the edge where the counter is 0, it SHALL perform the access, register rdata/err, set ack=1, and go to DONE.
REQ-017 DONE SHALL last exactly one cycle with ack=1, then go to IDLE with ack=0; req SHALL NOT be sampled in DONE, so a req held one cycle past ack is not re-captured.
REQ-018 The capture edge is k; ack SHALL be high from edge k+LATENCY to edge k+LATENCY+1; the earliest next capture is edge k+LATENCY+2.
REQ-019 A word index SHALL be addr[9:2] (log2(DEPTH)+1:2); byte lane SHALL be addr[1:0].
REQ-020 err SHALL be 1 when dtype=11, when the halfword has addr[0]=1, when the word has addr[1:0]!=0, or when the address is at or above DEPTH*4.
REQ-021 When err=1, rdata SHALL be 0 and memory SHALL be unchanged.
REQ-022 A load SHALL zero-extend the selected byte or halfword into rdata; a word SHALL be returned unchanged.
REQ-023 A store SHALL replace only the addressed byte lanes (read-modify-write of the word); rdata SHALL be 0 on a store ack.
REQ-024 Counter width SHALL be 4 bits; the counter SHALL NOT wrap, and WAIT SHALL exit at 0.
REQ-025 Storage contents SHALL NOT be reset and are undefined until written.

Reset
REQ-026 With rst_n=0 at posedge clk: state=IDLE, ack=0, err=0, rdata=0, counter=0, busy=0.
REQ-027 Reset in WAIT SHALL abort the transaction with no memory write and no ack.
REQ-028 Reset in DONE SHALL force ack=0 on that edge; a write already committed SHALL remain.

Structure
REQ-029 dtype encodings (BYTE, HALF, WORD) and state encodings SHALL live in a shared package/include alongside the processor's control parameter definitions.
REQ-030 One sub-module, mem_byte_lanes, SHALL implement the combinational lane merge for stores and the extract/zero-extend for loads; the FSM, counter and storage SHALL stay in respondedor_memoria.

Verification
REQ-031 Store word: LATENCY=2, store word 0xDEADBEEF to addr 0x10, then load word 0x10 -> ack exactly 2 edges after each capture, rdata=0xDEADBEEF, err=0.
REQ-032 Byte/half merge: store byte 0xAA to 0x11, then store half 0x1234 to 0x12 over word 0x00000000 at 0x10 -> load word 0x10 returns 0x1234AA00; load byte 0x11 returns 0x000000AA.
REQ-033 Errors: load half at 0x13, store word at 0x16, dtype=11, addr 0x400 -> each gives ack with err=1, rdata=0, and the target word unchanged.
REQ-034 Handshake: req held through DONE and dropped one cycle late -> exactly one ack; a back-to-back new req is captured at edge k+LATENCY+2.
REQ-035 Reset mid-op: store 0x55555555 to 0x20 (word initially 0x0), rst_n=0 during WAIT -> no ack; a later load of 0x20 returns 0x00000000.
REQ-036 LATENCY=1 and LATENCY=15 builds: ack at edge k+1 and k+15 respectively, with busy high for exactly LATENCY+1 cycles.

Source files
------------

// File: rtl/respondedor_memoria_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states, counter width
// and the alignment rule that both the FSM and the lane logic depend on.
package respondedor_memoria_pkg;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;
  localparam logic [1:0] DT_RSVD = 2'b11;

  localparam int CNT_W      = 4;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reserved size, odd halfword or non-word-aligned word is rejected.
  function automatic logic misaligned(input logic [1:0] dt, input logic [1:0] lane);
    return (dt == DT_RSVD) || (dt == DT_HALF && lane[0]) || (dt == DT_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/mem_byte_lanes.sv
// Combinational byte-lane logic: merges store data into the old word and
// extracts/zero-extends load data from it. No state, no latency.
module mem_byte_lanes
  import respondedor_memoria_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_dtype,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  always_comb begin
    o_merged = i_word;
    o_load   = 32'd0;
    case (i_dtype)
      DT_BYTE: begin
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
        o_load = {24'd0, i_word[{i_lane, 3'b000} +: 8]};
      end
      DT_HALF: begin
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_load = {16'd0, i_word[{i_lane[1], 4'b0000} +: 16]};
      end
      DT_WORD: begin
        o_merged = i_wdata;
        o_load   = i_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/respondedor_memoria.sv
// Single-port word memory answering one req/ack transaction at a time; ack arrives
// LATENCY edges after capture and lasts one cycle, new requests wait while busy.
module respondedor_memoria
  import respondedor_memoria_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  dtype,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [1:0]       r_dtype;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH];

  logic             w_access;
  logic             w_err;
  logic             w_wr_en;
  logic [AW-1:0]    w_idx;
  logic [31:0]      w_old;
  logic [31:0]      w_merged;
  logic [31:0]      w_load;

  assign w_idx   = r_addr[AW+1:2];
  assign w_old   = r_mem[w_idx];
  assign w_err   = misaligned(r_dtype, r_addr[1:0]) || (r_addr >= 32'(DEPTH * WORD_BYTES));
  assign w_wr_en = w_access && r_we && !w_err;
  assign rdata   = r_rdata;
  assign err     = r_err;

  mem_byte_lanes u_lanes (
    .i_word   (w_old),
    .i_wdata  (r_wdata),
    .i_lane   (r_addr[1:0]),
    .i_dtype  (r_dtype),
    .o_merged (w_merged),
    .o_load   (w_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req) w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ack      = (r_state == ST_DONE);
    busy     = (r_state != ST_IDLE);
    w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dtype <= DT_BYTE;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ST_IDLE && req) begin
      r_we    <= we;
      r_addr  <= addr;
      r_dtype <= dtype;
      r_wdata <= wdata;
      r_cnt   <= 4'(LATENCY - 1);
    end else if (r_state == ST_WAIT) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
      end
    end
  end

  // Storage is deliberately not reset; gating on rst_n drops a write that is aborted by reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) r_mem[w_idx] <= w_merged;
  end

endmodule

// File: tb/tb_respondedor_memoria.sv
// Directed bench for respondedor_memoria: three instances (LATENCY 2, 1, 15) share
// request fields; each has its own req and outputs.
module tb_respondedor_memoria;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  localparam logic [1:0] RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_v;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  dtype;
  logic [31:0] wdata;
  logic [2:0]  ack_v;
  logic [2:0]  err_v;
  logic [2:0]  busy_v;
  logic [31:0] rdata_v [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  respondedor_memoria #(.LATENCY(2), .DEPTH(256)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we), .addr(addr), .dtype(dtype),
    .wdata(wdata), .ack(ack_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .busy(busy_v[0]));

  respondedor_memoria #(.LATENCY(1), .DEPTH(256)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we), .addr(addr), .dtype(dtype),
    .wdata(wdata), .ack(ack_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .busy(busy_v[1]));

  respondedor_memoria #(.LATENCY(15), .DEPTH(256)) u_l15 (
    .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we), .addr(addr), .dtype(dtype),
    .wdata(wdata), .ack(ack_v[2]), .rdata(rdata_v[2]), .err(err_v[2]), .busy(busy_v[2]));

  function automatic int lat_of(input logic [1:0] d);
    case (d)
      2'd0:    return 2;
      2'd1:    return 1;
      default: return 15;
    endcase
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Issues one request on instance d; when hold=1 req stays high through the DONE edge.
  task automatic txn(input logic [1:0] d, input string tag, input logic w,
                     input logic [31:0] a, input logic [1:0] dt, input logic [31:0] wd,
                     input logic exp_e, input logic [31:0] exp_r, input logic hold);
    int n;
    int bcnt;
    we = w; addr = a; dtype = dt; wdata = wd;
    req_v[d] = 1'b1;
    @(posedge clk); #1;
    bcnt = busy_v[d] ? 1 : 0;
    addr = 32'hFFFF_FFF0; wdata = 32'h0BAD_0BAD; dtype = RSVD; we = ~w;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy_v[d]) bcnt++;
    end while (!ack_v[d] && n < 40);
    chk32({tag, ".lat"}, n, 32'(lat_of(d)));
    chk1({tag, ".err"}, err_v[d], exp_e);
    chk32({tag, ".rdata"}, rdata_v[d], exp_r);
    if (!hold) req_v[d] = 1'b0;
    @(posedge clk); #1;
    req_v[d] = 1'b0;
    chk1({tag, ".ack_clr"}, ack_v[d], 1'b0);
    chk1({tag, ".idle"}, busy_v[d], 1'b0);
    chk32({tag, ".busy_cyc"}, bcnt, 32'(lat_of(d) + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst_n = 1'b0; req_v = 3'b000; we = 1'b0; addr = '0; dtype = BYTE; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk1("rst.ack", ack_v[d], 1'b0);
      chk1("rst.busy", busy_v[d], 1'b0);
      chk1("rst.err", err_v[d], 1'b0);
      chk32("rst.rdata", rdata_v[d], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store/load
    txn(0, "st_w", 1'b1, 32'h10, WORD, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    txn(0, "ld_w", 1'b0, 32'h10, WORD, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte and halfword merge over a cleared word
    txn(0, "clr10", 1'b1, 32'h10, WORD, 32'h0, 1'b0, 32'h0, 1'b0);
    txn(0, "st_b", 1'b1, 32'h11, BYTE, 32'hFFFFFFAA, 1'b0, 32'h0, 1'b0);
    txn(0, "st_h", 1'b1, 32'h12, HALF, 32'hFFFF1234, 1'b0, 32'h0, 1'b0);
    txn(0, "ld_merge", 1'b0, 32'h10, WORD, 32'h0, 1'b0, 32'h1234AA00, 1'b0);
    txn(0, "ld_b11", 1'b0, 32'h11, BYTE, 32'h0, 1'b0, 32'h000000AA, 1'b0);
    txn(0, "ld_b13", 1'b0, 32'h13, BYTE, 32'h0, 1'b0, 32'h00000012, 1'b0);
    txn(0, "ld_h12", 1'b0, 32'h12, HALF, 32'h0, 1'b0, 32'h00001234, 1'b0);

    // Rejected requests leave memory untouched
    txn(0, "e_ldh13", 1'b0, 32'h13, HALF, 32'h0, 1'b1, 32'h0, 1'b0);
    txn(0, "st_w14", 1'b1, 32'h14, WORD, 32'h01020304, 1'b0, 32'h0, 1'b0);
    txn(0, "e_stw16", 1'b1, 32'h16, WORD, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
    txn(0, "ld_w14", 1'b0, 32'h14, WORD, 32'h0, 1'b0, 32'h01020304, 1'b0);
    txn(0, "e_ldrsv", 1'b0, 32'h10, RSVD, 32'h0, 1'b1, 32'h0, 1'b0);
    txn(0, "e_strsv", 1'b1, 32'h10, RSVD, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
    txn(0, "ld_w10", 1'b0, 32'h10, WORD, 32'h0, 1'b0, 32'h1234AA00, 1'b0);
    txn(0, "st_w0", 1'b1, 32'h0, WORD, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    txn(0, "e_st400", 1'b1, 32'h400, WORD, 32'h11111111, 1'b1, 32'h0, 1'b0);
    txn(0, "e_ld400", 1'b0, 32'h400, WORD, 32'h0, 1'b1, 32'h0, 1'b0);
    txn(0, "ld_w0", 1'b0, 32'h0, WORD, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
    txn(0, "st_3fc", 1'b1, 32'h3FC, WORD, 32'h600DF00D, 1'b0, 32'h0, 1'b0);
    txn(0, "ld_3fc", 1'b0, 32'h3FC, WORD, 32'h0, 1'b0, 32'h600DF00D, 1'b0);

    // req held one cycle past ack must not be re-captured
    txn(0, "hs", 1'b0, 32'h10, WORD, 32'h0, 1'b0, 32'h1234AA00, 1'b1);
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack_v[0]) acks++;
    end
    chk32("hs.single_ack", acks, 32'h0);

    // Reset during WAIT aborts the store
    txn(0, "clr20", 1'b1, 32'h20, WORD, 32'h0, 1'b0, 32'h0, 1'b0);
    txn(0, "pre_rst", 1'b0, 32'h10, WORD, 32'h0, 1'b0, 32'h1234AA00, 1'b0);
    we = 1'b1; addr = 32'h20; dtype = WORD; wdata = 32'h55555555;
    req_v[0] = 1'b1;
    @(posedge clk); #1;
    chk1("mid.busy", busy_v[0], 1'b1);
    rst_n = 1'b0; req_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk1("mid.ack", ack_v[0], 1'b0);
    chk1("mid.busy_clr", busy_v[0], 1'b0);
    chk32("mid.rdata", rdata_v[0], 32'h0);
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_v[0]) acks++;
    end
    chk32("mid.no_ack", acks, 32'h0);
    txn(0, "ld_w20", 1'b0, 32'h20, WORD, 32'h0, 1'b0, 32'h0, 1'b0);

    // Latency extremes
    txn(1, "l1.st", 1'b1, 32'h8, WORD, 32'hA5A55A5A, 1'b0, 32'h0, 1'b0);
    txn(1, "l1.ld", 1'b0, 32'h8, WORD, 32'h0, 1'b0, 32'hA5A55A5A, 1'b0);
    txn(1, "l1.ldb", 1'b0, 32'hA, BYTE, 32'h0, 1'b0, 32'h000000A5, 1'b0);
    txn(2, "l15.st", 1'b1, 32'h3FC, WORD, 32'h13579BDF, 1'b0, 32'h0, 1'b0);
    txn(2, "l15.ld", 1'b0, 32'h3FC, WORD, 32'h0, 1'b0, 32'h13579BDF, 1'b0);
    txn(2, "l15.err", 1'b0, 32'h3FE, HALF, 32'h0, 1'b0, 32'h00001357, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
